// File: rtl/soc_irq_pkg.sv
// ============================================================================
// Module   : soc_irq_pkg
// Brief    : Shared register map and sizing constants for the IRQ aggregator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package soc_irq_pkg;

  // Word addresses of the slave register file
  localparam logic [2:0] ADDR_RAW    = 3'd0;
  localparam logic [2:0] ADDR_PEND   = 3'd1;
  localparam logic [2:0] ADDR_MASK   = 3'd2;
  localparam logic [2:0] ADDR_MODE   = 3'd3;
  localparam logic [2:0] ADDR_ACTIVE = 3'd4;
  localparam logic [2:0] ADDR_FORCE  = 3'd5;

  // Source count ceiling; also the slave data width
  localparam int MAX_IRQ          = 16;
  localparam int DATA_W           = MAX_IRQ;
  localparam int ACTIVE_VALID_BIT = 15;

endpackage : soc_irq_pkg

`default_nettype wire

// File: rtl/soc_irq_prio_enc.sv
// ============================================================================
// Module   : soc_irq_prio_enc
// Brief    : Combinational lowest-index-first priority encoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module soc_irq_prio_enc #(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = 4
) (
  input  logic [NUM_IRQ-1:0] i_req,
  output logic               o_valid,
  output logic [ID_W-1:0]    o_idx
);

  // Scan downwards so the lowest set index is the last one assigned
  always_comb begin
    o_valid = |i_req;
    o_idx   = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx = ID_W'(i);
      end
    end
  end

endmodule : soc_irq_prio_enc

`default_nettype wire

// File: rtl/soc_irq_ctrl.sv
// ============================================================================
// Module   : soc_irq_ctrl
// Brief    : Interrupt aggregator with per-source mask, level/edge capture,
//            registered CPU request + source ID and an Avalon-MM slave.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module soc_irq_ctrl
  import soc_irq_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  output logic               irq_out,
  output logic [ID_W-1:0]    irq_id
);

  logic [NUM_IRQ-1:0] r_s1;
  logic [NUM_IRQ-1:0] r_s2;
  logic [NUM_IRQ-1:0] r_s3;
  logic [NUM_IRQ-1:0] r_edge_pend;
  logic [NUM_IRQ-1:0] r_mask;
  logic [NUM_IRQ-1:0] r_mode;
  logic [DATA_W-1:0]  r_readdata;
  logic               r_irq_out;
  logic [ID_W-1:0]    r_irq_id;

  logic               w_wr;
  logic               w_wr_pend;
  logic               w_wr_mask;
  logic               w_wr_mode;
  logic               w_wr_force;
  logic [NUM_IRQ-1:0] w_wdata;
  logic [NUM_IRQ-1:0] w_edge_set;
  logic [NUM_IRQ-1:0] w_pend_clr;
  logic [NUM_IRQ-1:0] w_mode_clr;
  logic [NUM_IRQ-1:0] w_edge_pend_nxt;
  logic [NUM_IRQ-1:0] w_eff_pend;
  logic [NUM_IRQ-1:0] w_active;
  logic               w_any;
  logic [ID_W-1:0]    w_idx;
  logic [DATA_W-1:0]  w_rd_nxt;
  logic               w_unused_wdata;

  // --------------------------------------------------------------------------
  // Slave write decode
  // --------------------------------------------------------------------------
  assign w_wr       = chipselect & ~write_n;
  assign w_wr_pend  = w_wr & (address == ADDR_PEND);
  assign w_wr_mask  = w_wr & (address == ADDR_MASK);
  assign w_wr_mode  = w_wr & (address == ADDR_MODE);
  assign w_wr_force = w_wr & (address == ADDR_FORCE);
  assign w_wdata    = writedata[NUM_IRQ-1:0];

  // Bits above the source count carry no meaning
  assign w_unused_wdata = ^writedata;

  // --------------------------------------------------------------------------
  // Synchronizer and edge-detect delay
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= irq_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // --------------------------------------------------------------------------
  // Edge capture: set beats W1C; a mode change discards any stale capture.
  // Capture is gated by mode, so a level-mode bit never holds edge_pend.
  // --------------------------------------------------------------------------
  assign w_edge_set      = (r_mode & r_s2 & ~r_s3)
                         | (w_wr_force ? (w_wdata & r_mode) : '0);
  assign w_pend_clr      = w_wr_pend ? w_wdata : '0;
  assign w_mode_clr      = w_wr_mode ? (w_wdata ^ r_mode) : '0;
  assign w_edge_pend_nxt = ((r_edge_pend & ~w_pend_clr) | w_edge_set) & ~w_mode_clr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edge_pend <= '0;
      r_mask      <= '0;
      r_mode      <= '0;
    end else begin
      r_edge_pend <= w_edge_pend_nxt;
      if (w_wr_mask) begin
        r_mask <= w_wdata;
      end
      if (w_wr_mode) begin
        r_mode <= w_wdata;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Effective pending: level bits follow the synchronized input directly
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_bit
    assign w_eff_pend[i] = r_mode[i] ? r_edge_pend[i] : r_s2[i];
  end

  assign w_active = w_eff_pend & r_mask;

  soc_irq_prio_enc #(
    .NUM_IRQ (NUM_IRQ),
    .ID_W    (ID_W)
  ) u_prio_enc (
    .i_req   (w_active),
    .o_valid (w_any),
    .o_idx   (w_idx)
  );

  // --------------------------------------------------------------------------
  // CPU request
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_out <= 1'b0;
      r_irq_id  <= '0;
    end else begin
      r_irq_out <= w_any;
      r_irq_id  <= w_any ? w_idx : '0;
    end
  end

  // --------------------------------------------------------------------------
  // Read mux; sampled from pre-write state so same-cycle writes are invisible
  // --------------------------------------------------------------------------
  always_comb begin
    w_rd_nxt = '0;
    case (address)
      ADDR_RAW:    w_rd_nxt[NUM_IRQ-1:0] = r_s2;
      ADDR_PEND:   w_rd_nxt[NUM_IRQ-1:0] = w_eff_pend;
      ADDR_MASK:   w_rd_nxt[NUM_IRQ-1:0] = r_mask;
      ADDR_MODE:   w_rd_nxt[NUM_IRQ-1:0] = r_mode;
      ADDR_ACTIVE: begin
        w_rd_nxt[ACTIVE_VALID_BIT] = w_any;
        w_rd_nxt[ID_W-1:0]         = w_any ? w_idx : '0;
      end
      default:     w_rd_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
    end else begin
      r_readdata <= w_rd_nxt;
    end
  end

  assign readdata = r_readdata;
  assign irq_out  = r_irq_out;
  assign irq_id   = r_irq_id;

endmodule : soc_irq_ctrl

`default_nettype wire

// File: tb/tb_soc_irq_ctrl.sv
// ============================================================================
// Module   : tb_soc_irq_ctrl
// Brief    : Directed, table-driven self-checking bench for soc_irq_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_soc_irq_ctrl;

  logic        clk;
  logic        reset_n;
  logic [7:0]  irq_in;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        irq_out;
  logic [3:0]  irq_id;

  int n_checks;
  int n_fail;

  typedef struct packed {
    logic        wr;
    logic [2:0]  addr;
    logic [15:0] data;
    logic [7:0]  irq;
    logic [15:0] exp_rd;
    logic        exp_irq;
    logic [3:0]  exp_id;
  } vec_t;

  localparam int NVEC = 24;
  vec_t vecs [NVEC];

  soc_irq_ctrl #(
    .NUM_IRQ (8),
    .ID_W    (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .irq_in     (irq_in),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq_out    (irq_out),
    .irq_id     (irq_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] d);
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = a;
    tick();
    d          = readdata;
    chipselect = 1'b0;
  endtask

  initial begin
    logic [15:0] v;
    n_checks   = 0;
    n_fail     = 0;
    reset_n    = 1'b0;
    irq_in     = '0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;

    // {wr, addr, data, irq_in, expected readdata, irq_out, irq_id} after the edge
    vecs[0]  = '{1'b0, 3'd2, 16'h0000, 8'h00, 16'h0000, 1'b0, 4'd0};
    vecs[1]  = '{1'b1, 3'd2, 16'hFFA5, 8'h00, 16'h0000, 1'b0, 4'd0};
    vecs[2]  = '{1'b0, 3'd2, 16'h0000, 8'h00, 16'h00A5, 1'b0, 4'd0};
    vecs[3]  = '{1'b1, 3'd3, 16'h0F0F, 8'h00, 16'h0000, 1'b0, 4'd0};
    vecs[4]  = '{1'b0, 3'd3, 16'h0000, 8'h00, 16'h000F, 1'b0, 4'd0};
    vecs[5]  = '{1'b1, 3'd0, 16'h00FF, 8'h00, 16'h0000, 1'b0, 4'd0};
    vecs[6]  = '{1'b0, 3'd6, 16'h0000, 8'h00, 16'h0000, 1'b0, 4'd0};
    vecs[7]  = '{1'b1, 3'd7, 16'hFFFF, 8'h00, 16'h0000, 1'b0, 4'd0};
    vecs[8]  = '{1'b0, 3'd2, 16'h0000, 8'h00, 16'h00A5, 1'b0, 4'd0};
    vecs[9]  = '{1'b0, 3'd5, 16'h0000, 8'h00, 16'h0000, 1'b0, 4'd0};
    vecs[10] = '{1'b1, 3'd2, 16'h0000, 8'h00, 16'h00A5, 1'b0, 4'd0};
    vecs[11] = '{1'b1, 3'd3, 16'h0000, 8'h00, 16'h000F, 1'b0, 4'd0};
    vecs[12] = '{1'b0, 3'd3, 16'h0000, 8'h00, 16'h0000, 1'b0, 4'd0};
    vecs[13] = '{1'b1, 3'd2, 16'h00FF, 8'h28, 16'h0000, 1'b0, 4'd0};
    vecs[14] = '{1'b0, 3'd0, 16'h0000, 8'h28, 16'h0000, 1'b0, 4'd0};
    vecs[15] = '{1'b0, 3'd0, 16'h0000, 8'h28, 16'h0028, 1'b1, 4'd3};
    vecs[16] = '{1'b0, 3'd4, 16'h0000, 8'h28, 16'h8003, 1'b1, 4'd3};
    vecs[17] = '{1'b0, 3'd4, 16'h0000, 8'h20, 16'h8003, 1'b1, 4'd3};
    vecs[18] = '{1'b0, 3'd4, 16'h0000, 8'h20, 16'h8003, 1'b1, 4'd3};
    vecs[19] = '{1'b0, 3'd4, 16'h0000, 8'h20, 16'h8005, 1'b1, 4'd5};
    vecs[20] = '{1'b0, 3'd4, 16'h0000, 8'h00, 16'h8005, 1'b1, 4'd5};
    vecs[21] = '{1'b0, 3'd4, 16'h0000, 8'h00, 16'h8005, 1'b1, 4'd5};
    vecs[22] = '{1'b0, 3'd4, 16'h0000, 8'h00, 16'h0000, 1'b0, 4'd0};
    vecs[23] = '{1'b0, 3'd1, 16'h0000, 8'h00, 16'h0000, 1'b0, 4'd0};

    // Reset state
    tick();
    tick();
    check("reset irq_out", {15'd0, irq_out}, 16'h0000);
    check("reset irq_id", {12'd0, irq_id}, 16'h0000);
    check("reset readdata", readdata, 16'h0000);
    #3 reset_n = 1'b1;
    tick();

    // Register map and priority table
    for (int i = 0; i < NVEC; i++) begin
      chipselect = 1'b1;
      write_n    = ~vecs[i].wr;
      address    = vecs[i].addr;
      writedata  = vecs[i].data;
      irq_in     = vecs[i].irq;
      tick();
      check($sformatf("vec%0d readdata", i), readdata, vecs[i].exp_rd);
      check($sformatf("vec%0d irq_out", i), {15'd0, irq_out}, {15'd0, vecs[i].exp_irq});
      check($sformatf("vec%0d irq_id", i), {12'd0, irq_id}, {12'd0, vecs[i].exp_id});
    end
    chipselect = 1'b0;
    write_n    = 1'b1;

    // Level path latency
    wr(3'd2, 16'h0001);
    irq_in = 8'h01;
    tick();
    tick();
    check("level rise +2", {15'd0, irq_out}, 16'h0000);
    tick();
    check("level rise +3", {15'd0, irq_out}, 16'h0001);
    check("level id", {12'd0, irq_id}, 16'h0000);
    irq_in = 8'h00;
    tick();
    tick();
    check("level fall +2", {15'd0, irq_out}, 16'h0001);
    tick();
    check("level fall +3", {15'd0, irq_out}, 16'h0000);

    // Edge capture and W1C
    wr(3'd3, 16'h0004);
    wr(3'd2, 16'h0004);
    irq_in = 8'h04;
    tick();
    irq_in = 8'h00;
    tick();
    tick();
    check("edge +3", {15'd0, irq_out}, 16'h0000);
    tick();
    check("edge +4", {15'd0, irq_out}, 16'h0001);
    check("edge id", {12'd0, irq_id}, 16'h0002);
    tick();
    tick();
    check("edge held", {15'd0, irq_out}, 16'h0001);
    rd(3'd1, v);
    check("edge pending", v, 16'h0004);
    wr(3'd1, 16'h0004);
    check("w1c same edge", {15'd0, irq_out}, 16'h0001);
    tick();
    check("w1c next", {15'd0, irq_out}, 16'h0000);
    rd(3'd1, v);
    check("w1c pending", v, 16'h0000);

    // Set-vs-clear race: the edge lands on the same edge as the W1C write
    wr(3'd3, 16'h0002);
    wr(3'd2, 16'h0002);
    irq_in = 8'h02;
    tick();
    tick();
    wr(3'd1, 16'h0002);
    rd(3'd1, v);
    check("race pending", v, 16'h0002);
    check("race irq_out", {15'd0, irq_out}, 16'h0001);
    wr(3'd1, 16'h0002);
    rd(3'd1, v);
    check("race cleared", v, 16'h0000);
    irq_in = 8'h00;
    tick();
    tick();

    // Mask, FORCE and mode-change clear
    wr(3'd3, 16'h0080);
    wr(3'd2, 16'h0000);
    wr(3'd5, 16'h0080);
    rd(3'd1, v);
    check("force pending", v, 16'h0080);
    tick();
    check("force masked", {15'd0, irq_out}, 16'h0000);
    wr(3'd2, 16'h0080);
    check("unmask same edge", {15'd0, irq_out}, 16'h0000);
    tick();
    check("unmask next", {15'd0, irq_out}, 16'h0001);
    check("unmask id", {12'd0, irq_id}, 16'h0007);
    wr(3'd5, 16'h0001);
    rd(3'd1, v);
    check("force level ignored", v, 16'h0080);
    wr(3'd3, 16'h0000);
    wr(3'd3, 16'h0080);
    rd(3'd1, v);
    check("mode change clears", v, 16'h0000);

    // Asynchronous reset mid-operation with a source held high
    wr(3'd3, 16'h000F);
    wr(3'd2, 16'h00FF);
    wr(3'd5, 16'h000F);
    irq_in = 8'h01;
    tick();
    tick();
    tick();
    check("pre-reset irq_out", {15'd0, irq_out}, 16'h0001);
    rd(3'd2, v);
    check("pre-reset mask", v, 16'h00FF);
    chipselect = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("async rst irq_out", {15'd0, irq_out}, 16'h0000);
    check("async rst irq_id", {12'd0, irq_id}, 16'h0000);
    check("async rst readdata", readdata, 16'h0000);
    tick();
    check("in rst readdata", readdata, 16'h0000);
    #3 reset_n = 1'b1;
    chipselect = 1'b0;
    tick();
    tick();
    tick();
    tick();
    rd(3'd2, v);
    check("post-rst mask", v, 16'h0000);
    rd(3'd3, v);
    check("post-rst mode", v, 16'h0000);
    rd(3'd0, v);
    check("post-rst raw", v, 16'h0001);
    rd(3'd1, v);
    check("post-rst level pend", v, 16'h0001);
    wr(3'd3, 16'h0001);
    rd(3'd1, v);
    check("no edge across reset", v, 16'h0000);
    wr(3'd2, 16'h0001);
    tick();
    check("no irq across reset", {15'd0, irq_out}, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_soc_irq_ctrl

`default_nettype wire
